// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: writeback source select, load funct3 codes and
// the MEM/WB pipeline register layout.
package rv32i_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // wb_sel is kept as raw bits so the reserved code 2'b11 can be stored as-is.
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] load_data;
  } mem_wb_t;

endpackage

// File: rtl/load_aligner.sv
// Combinational load extraction: picks the addressed byte/halfword out of the
// memory word, sign/zero-extends it, and flags misaligned halfword/word loads.
module load_aligner
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (offset)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{w_byte[7]}}, w_byte};
      F3_LBU: data = {24'b0, w_byte};
      F3_LH: begin
        data       = {{16{w_half[15]}}, w_half};
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = {16'b0, w_half};
        misaligned = offset[0];
      end
      // LW and every unlisted funct3 behave as a full-word load.
      default: begin
        data       = word;
        misaligned = |offset;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback source mux, register-file write enable
// generation and retired-instruction counter for the RV32I 5-stage core.
module writeback_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_wb_sel,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic [XLEN-1:0] mem_load_data,
  output logic [XLEN-1:0] register_file_data,
  output logic [4:0]      rd,
  output logic            en,
  output logic            wb_valid,
  output logic            load_misaligned,
  output logic [XLEN-1:0] retired_count
);

  mem_wb_t     r_wb;
  logic [31:0] r_retired_count;
  mem_wb_t     w_capture;
  logic [31:0] w_load_data;
  logic        w_load_mis;
  logic [31:0] w_selected;

  // Control priority: reset, then flush (bubble), then stall (hold), then capture.
  always_comb begin
    w_capture            = '0;
    w_capture.valid      = mem_valid;
    w_capture.reg_write  = mem_reg_write;
    w_capture.rd         = mem_rd;
    w_capture.wb_sel     = mem_wb_sel;
    w_capture.funct3     = mem_funct3;
    w_capture.alu_result = mem_alu_result;
    w_capture.pc_plus4   = mem_pc_plus4;
    w_capture.load_data  = mem_load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb <= '0;
    end else if (flush) begin
      r_wb <= '0;
    end else if (!stall) begin
      r_wb <= w_capture;
    end
  end

  // An instruction retires on the edge it leaves WB, so a stalled one counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired_count <= '0;
    end else if (r_wb.valid && !stall) begin
      r_retired_count <= r_retired_count + 32'd1;
    end
  end

  load_aligner u_load_aligner (
    .funct3     (r_wb.funct3),
    .offset     (r_wb.alu_result[1:0]),
    .word       (r_wb.load_data),
    .data       (w_load_data),
    .misaligned (w_load_mis)
  );

  always_comb begin
    case (r_wb.wb_sel)
      WB_LOAD: w_selected = w_load_data;
      WB_PC4:  w_selected = r_wb.pc_plus4;
      default: w_selected = r_wb.alu_result;
    endcase
  end

  assign wb_valid           = r_wb.valid;
  assign rd                 = r_wb.rd;
  assign load_misaligned    = r_wb.valid && (r_wb.wb_sel == WB_LOAD) && w_load_mis;
  assign en                 = r_wb.valid && r_wb.reg_write && (r_wb.rd != 5'd0) && !load_misaligned;
  assign register_file_data = r_wb.valid ? w_selected : 32'd0;
  assign retired_count      = r_retired_count;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, stall/flush/
// reset/wrap sequences and randomized traffic against a behavioural model.
module tb_writeback_stage;
  import rv32i_pkg::*;

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] ld;
  } in_t;

  typedef struct {
    string       name;
    in_t         in;
    logic [31:0] e_data;
    logic        e_en;
    logic        e_mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_reg_write = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [1:0]  mem_wb_sel = '0;
  logic [2:0]  mem_funct3 = '0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_pc_plus4 = '0;
  logic [31:0] mem_load_data = '0;
  logic [31:0] register_file_data;
  logic [4:0]  rd;
  logic        en;
  logic        wb_valid;
  logic        load_misaligned;
  logic [31:0] retired_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the instruction currently in WB and the retire count.
  in_t         m_wb;
  logic [31:0] m_cnt;
  in_t         cur;

  writeback_stage #(.XLEN(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .flush              (flush),
    .mem_valid          (mem_valid),
    .mem_reg_write      (mem_reg_write),
    .mem_rd             (mem_rd),
    .mem_wb_sel         (mem_wb_sel),
    .mem_funct3         (mem_funct3),
    .mem_alu_result     (mem_alu_result),
    .mem_pc_plus4       (mem_pc_plus4),
    .mem_load_data      (mem_load_data),
    .register_file_data (register_file_data),
    .rd                 (rd),
    .en                 (en),
    .wb_valid           (wb_valid),
    .load_misaligned    (load_misaligned),
    .retired_count      (retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic in_t bubble();
    in_t x;
    x = '{v: 1'b0, rw: 1'b0, rd: 5'd0, sel: 2'd0, f3: 3'd0, alu: 32'd0, pc4: 32'd0, ld: 32'd0};
    return x;
  endfunction

  function automatic in_t mk(input logic rw, input logic [4:0] r, input logic [1:0] s,
                             input logic [2:0] f, input logic [31:0] a, input logic [31:0] p,
                             input logic [31:0] l);
    in_t x;
    x = '{v: 1'b1, rw: rw, rd: r, sel: s, f3: f, alu: a, pc4: p, ld: l};
    return x;
  endfunction

  // Access size in bytes: byte loads 1, halfword loads 2, everything else a word.
  function automatic int ref_size(input logic [2:0] f);
    if (f == F3_LB || f == F3_LBU) return 1;
    if (f == F3_LH || f == F3_LHU) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    int          sz;
    sz = ref_size(f);
    if (sz == 1) begin
      sh = w >> (8 * off);
      return (f == F3_LB) ? 32'($signed(sh[7:0])) : {24'd0, sh[7:0]};
    end
    if (sz == 2) begin
      sh = w >> (16 * off[1]);
      return (f == F3_LH) ? 32'($signed(sh[15:0])) : {16'd0, sh[15:0]};
    end
    return w;
  endfunction

  function automatic logic ref_mis(input in_t x);
    if (!x.v || x.sel != 2'b01) return 1'b0;
    return (int'(x.alu[1:0]) % ref_size(x.f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_data(input in_t x);
    if (!x.v) return 32'd0;
    if (x.sel == 2'b01) return ref_load(x.f3, x.alu[1:0], x.ld);
    if (x.sel == 2'b10) return x.pc4;
    return x.alu;
  endfunction

  function automatic logic ref_en(input in_t x);
    return x.v && x.rw && (x.rd != 0) && !ref_mis(x);
  endfunction

  task automatic drive(input in_t x, input logic s, input logic f);
    cur            = x;
    stall          = s;
    flush          = f;
    mem_valid      = x.v;
    mem_reg_write  = x.rw;
    mem_rd         = x.rd;
    mem_wb_sel     = x.sel;
    mem_funct3     = x.f3;
    mem_alu_result = x.alu;
    mem_pc_plus4   = x.pc4;
    mem_load_data  = x.ld;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 32'(wb_valid), 32'(m_wb.v));
    chk({tag, ".rd"}, 32'(rd), 32'(m_wb.rd));
    chk({tag, ".en"}, 32'(en), 32'(ref_en(m_wb)));
    chk({tag, ".mis"}, 32'(load_misaligned), 32'(ref_mis(m_wb)));
    chk({tag, ".data"}, register_file_data, ref_data(m_wb));
    chk({tag, ".count"}, retired_count, m_cnt);
  endtask

  // One rising edge: advance the model exactly as the rules describe, then sample.
  task automatic tick(input string tag);
    @(posedge clk);
    if (m_wb.v && !stall) m_cnt = m_cnt + 32'd1;
    if (flush) m_wb = bubble();
    else if (!stall) m_wb = cur;
    #1;
    compare_all(tag);
  endtask

  vec_t        vecs[$];
  logic [31:0] held_data;
  logic [31:0] c0;
  localparam logic [31:0] LDW = 32'h80FF_7F01;

  initial begin
    m_wb  = bubble();
    m_cnt = 32'd0;
    drive(bubble(), 1'b0, 1'b0);

    // Reset state.
    #12;
    chk("reset.valid", 32'(wb_valid), 32'd0);
    chk("reset.en", 32'(en), 32'd0);
    chk("reset.data", register_file_data, 32'd0);
    chk("reset.count", retired_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{"alu_rd5", mk(1, 5, 2'b00, F3_LW, 32'h1234_5678, 32'h0, 32'h0), 32'h1234_5678, 1, 0});
    vecs.push_back('{"lb_off3", mk(1, 6, 2'b01, F3_LB, 32'h0000_1003, 32'h0, LDW), 32'hFFFF_FF80, 1, 0});
    vecs.push_back('{"lbu_off3", mk(1, 6, 2'b01, F3_LBU, 32'h0000_1003, 32'h0, LDW), 32'h0000_0080, 1, 0});
    vecs.push_back('{"lh_off2", mk(1, 7, 2'b01, F3_LH, 32'h0000_1002, 32'h0, LDW), 32'hFFFF_80FF, 1, 0});
    vecs.push_back('{"lhu_off0", mk(1, 7, 2'b01, F3_LHU, 32'h0000_1000, 32'h0, LDW), 32'h0000_7F01, 1, 0});
    vecs.push_back('{"lw_off0", mk(1, 8, 2'b01, F3_LW, 32'h0000_1000, 32'h0, LDW), 32'h80FF_7F01, 1, 0});
    vecs.push_back('{"lh_off1_mis", mk(1, 9, 2'b01, F3_LH, 32'h0000_1001, 32'h0, LDW), 32'h0000_7F01, 0, 1});
    vecs.push_back('{"lw_off2_mis", mk(1, 9, 2'b01, F3_LW, 32'h0000_1002, 32'h0, LDW), 32'h80FF_7F01, 0, 1});
    vecs.push_back('{"jal_rd0", mk(1, 0, 2'b10, F3_LB, 32'h0000_0200, 32'h104, LDW), 32'h0000_0104, 0, 0});
    vecs.push_back('{"jal_rd1", mk(1, 1, 2'b10, F3_LB, 32'h0000_0200, 32'h104, LDW), 32'h0000_0104, 1, 0});
    vecs.push_back('{"sel11_alu", mk(1, 3, 2'b11, F3_LB, 32'hCAFE_0001, 32'h104, LDW), 32'hCAFE_0001, 1, 0});
    vecs.push_back('{"f3_011_lw", mk(1, 4, 2'b01, 3'b011, 32'h0000_0000, 32'h0, LDW), 32'h80FF_7F01, 1, 0});
    vecs.push_back('{"no_regwrite", mk(0, 4, 2'b00, F3_LW, 32'h0000_0055, 32'h0, LDW), 32'h0000_0055, 0, 0});

    foreach (vecs[i]) begin
      c0 = m_cnt;
      drive(vecs[i].in, 1'b0, 1'b0);
      tick(vecs[i].name);
      chk({vecs[i].name, ".tbl_data"}, register_file_data, vecs[i].e_data);
      chk({vecs[i].name, ".tbl_en"}, 32'(en), 32'(vecs[i].e_en));
      chk({vecs[i].name, ".tbl_mis"}, 32'(load_misaligned), 32'(vecs[i].e_mis));
      chk({vecs[i].name, ".tbl_count"}, retired_count, (i == 0) ? 32'd0 : c0 + 32'd1);
    end

    // Flush loads a bubble.
    drive(mk(1, 5, 2'b00, F3_LW, 32'h1, 32'h0, 32'h0), 1'b0, 1'b1);
    tick("flush");
    chk("flush.tbl_valid", 32'(wb_valid), 32'd0);
    chk("flush.tbl_data", register_file_data, 32'd0);

    // Stall holds an ADD for three edges; it counts only on the release edge.
    drive(mk(1, 7, 2'b00, F3_LW, 32'h0000_00AD, 32'h0, 32'h0), 1'b0, 1'b0);
    tick("add");
    held_data = register_file_data;
    c0 = retired_count;
    for (int k = 0; k < 3; k++) begin
      drive(mk(1, 9, 2'b10, F3_LW, 32'hDEAD_0000 + k, 32'h888, 32'h0), 1'b1, 1'b0);
      tick("stall");
      chk("stall.tbl_data", register_file_data, 32'h0000_00AD);
      chk("stall.tbl_en", 32'(en), 32'd1);
      chk("stall.tbl_count", retired_count, c0);
    end
    drive(mk(1, 10, 2'b00, F3_LW, 32'h0000_0BEE, 32'h0, 32'h0), 1'b0, 1'b0);
    tick("release");
    chk("release.tbl_count", retired_count, c0 + 32'd1);
    chk("release.tbl_held", held_data, 32'h0000_00AD);

    // Flush together with stall: bubble wins, no increment.
    c0 = retired_count;
    drive(mk(1, 11, 2'b00, F3_LW, 32'h0000_0001, 32'h0, 32'h0), 1'b1, 1'b1);
    tick("flush_stall");
    chk("flush_stall.tbl_valid", 32'(wb_valid), 32'd0);
    chk("flush_stall.tbl_count", retired_count, c0);

    // Asynchronous reset mid-stream.
    drive(mk(1, 12, 2'b00, F3_LW, 32'h0000_7777, 32'h0, 32'h0), 1'b0, 1'b0);
    tick("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    m_wb  = bubble();
    m_cnt = 32'd0;
    chk("async_rst.valid", 32'(wb_valid), 32'd0);
    chk("async_rst.en", 32'(en), 32'd0);
    chk("async_rst.rd", 32'(rd), 32'd0);
    chk("async_rst.data", register_file_data, 32'd0);
    chk("async_rst.count", retired_count, 32'd0);
    #1;
    rst = 1'b0;
    drive(mk(1, 5, 2'b00, F3_LW, 32'h1234_5678, 32'h0, 32'h0), 1'b0, 1'b0);
    tick("post_rst");
    chk("post_rst.tbl_en", 32'(en), 32'd1);
    chk("post_rst.tbl_rd", 32'(rd), 32'd5);
    chk("post_rst.tbl_data", register_file_data, 32'h1234_5678);

    // Counter wrap: preload near the top, then retire three instructions.
    drive(bubble(), 1'b0, 1'b1);
    tick("pre_wrap");
    force dut.r_retired_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_retired_count;
    m_cnt = 32'hFFFF_FFFE;
    for (int k = 0; k < 4; k++) begin
      drive((k < 3) ? mk(1, 5'(k + 1), 2'b00, F3_LW, 32'(k), 32'h0, 32'h0) : bubble(), 1'b0, 1'b0);
      tick("wrap");
    end
    chk("wrap.tbl_count", retired_count, 32'h0000_0001);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      in_t x;
      x.v   = ($urandom_range(0, 3) != 0);
      x.rw  = ($urandom_range(0, 3) != 0);
      x.rd  = 5'($urandom_range(0, 31));
      x.sel = 2'($urandom_range(0, 3));
      x.f3  = 3'($urandom_range(0, 7));
      x.alu = $urandom;
      x.pc4 = $urandom;
      x.ld  = $urandom;
      drive(x, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
